// File: rtl/fetch_prefetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : fetch_prefetch                                                |
// | Description: Instruction fetch stage with a DEPTH-entry prefetch FIFO and  |
// |              up to MAX_OUTSTANDING pipelined Wishbone reads in flight.     |
// |              Sequential word reads are issued ahead of consumption. Every  |
// |              request is issued only when a FIFO slot is guaranteed for its |
// |              ack. A pc_flush redirects fetch and discards stale data,      |
// |              including acks that are still in flight.                      |
// | Config     : FETCH_PC_EN - when defined, adds the o_pc port. Each FIFO     |
// |              entry then also stores the address of the request that        |
// |              returned the word.                                            |
// | Ports      : clk, rst (async, active-high)                                 |
// |              Bus  : o_stb, i_stall, i_ack, o_adr, o_sel, o_we, i_dat_r,    |
// |                     o_dat_w                                                |
// |              Pipe : i_ready, o_valid, o_instr, o_pc (FETCH_PC_EN only)     |
// |              Ctrl : i_pc_flush, i_pc_new                                   |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module fetch_prefetch #(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  // pipelined Wishbone instruction master
  output logic        o_stb,
  input  logic        i_stall,
  input  logic        i_ack,
  output logic [31:0] o_adr,
  output logic [3:0]  o_sel,
  output logic        o_we,
  input  logic [31:0] i_dat_r,
  output logic [31:0] o_dat_w,
  // decode-side valid/ready pipe
  input  logic        i_ready,
  output logic        o_valid,
  output logic [31:0] o_instr,
`ifdef FETCH_PC_EN
  output logic [31:0] o_pc,
`endif
  // redirect
  input  logic        i_pc_flush,
  input  logic [31:0] i_pc_new
);

  localparam int unsigned c_OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned c_PTR_W = $clog2(DEPTH);
  localparam int unsigned c_CNT_W = $clog2(DEPTH + 1);
`ifdef FETCH_PC_EN
  localparam int unsigned c_ENTRY_W = 64;
`else
  localparam int unsigned c_ENTRY_W = 32;
`endif

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [31:0]          r_fetch_pc;
  logic [c_OUT_W-1:0]   r_outstanding;
  logic [c_OUT_W-1:0]   r_discard;
  logic [c_PTR_W-1:0]   r_wptr;
  logic [c_PTR_W-1:0]   r_rptr;
  logic [c_CNT_W-1:0]   r_count;
  logic [c_ENTRY_W-1:0] r_mem [DEPTH];

  // --------------------------------------------------------------------------
  // Combinational control
  // --------------------------------------------------------------------------
  logic [31:0]          w_out_ext;
  logic [31:0]          w_count_ext;
  logic                 w_slot_ok;
  logic                 w_credit_ok;
  logic                 w_stb;
  logic                 w_accept;
  logic                 w_ack_ok;
  logic                 w_drop;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_valid;
  logic [c_ENTRY_W-1:0] w_entry;
  logic [c_ENTRY_W-1:0] w_head;
  logic [c_OUT_W-1:0]   w_out_after_ack;
  logic [1:0]           w_unused_pc_lsb;

  assign w_out_ext   = 32'(r_outstanding);
  assign w_count_ext = 32'(r_count);

  // Credit: words already buffered plus words still on the bus must fit the
  // FIFO, so every ack is guaranteed a slot and the FIFO cannot overflow.
  assign w_slot_ok   = w_out_ext < MAX_OUTSTANDING;
  assign w_credit_ok = (w_count_ext + w_out_ext) < DEPTH;

  // rst is folded in so the strobe drops the instant reset is asserted,
  // rather than reflecting the freshly cleared (and credit-rich) counters.
  assign w_stb    = !rst && !i_pc_flush && w_slot_ok && w_credit_ok;
  assign w_accept = w_stb && !i_stall;

  // An ack with nothing outstanding is a protocol error; ignore it entirely.
  assign w_ack_ok = i_ack && (r_outstanding != '0);
  assign w_drop   = w_ack_ok && (r_discard != '0);
  assign w_push   = w_ack_ok && !w_drop && !i_pc_flush;
  assign w_valid  = r_count != '0;
  assign w_pop    = w_valid && i_ready && !i_pc_flush;

  assign w_out_after_ack = r_outstanding - c_OUT_W'(w_ack_ok);

  // Target alignment bits are forced to zero on redirect.
  assign w_unused_pc_lsb = i_pc_new[1:0];

`ifdef FETCH_PC_EN
  // Requests between discards are strictly sequential, so the oldest live
  // request sits r_outstanding words behind the next fetch address. A pushed
  // ack always has r_discard == 0, so every outstanding request is live.
  logic [31:0] w_ack_adr;
  assign w_ack_adr = r_fetch_pc - (w_out_ext << 2);
  assign w_entry   = {w_ack_adr, i_dat_r};
`else
  assign w_entry   = i_dat_r;
`endif

  assign w_head = r_mem[r_rptr];

  // --------------------------------------------------------------------------
  // Fetch address and bus bookkeeping
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_outstanding <= '0;
      r_discard     <= '0;
    end else if (i_pc_flush) begin
      // stb is low during a flush, so only an ack can change the count.
      // Everything still in flight after this cycle's ack is stale.
      r_fetch_pc    <= {i_pc_new[31:2], 2'b00};
      r_outstanding <= w_out_after_ack;
      r_discard     <= w_out_after_ack;
    end else begin
      if (w_accept) begin
        r_fetch_pc <= r_fetch_pc + 32'd4;
      end
      r_outstanding <= r_outstanding + c_OUT_W'(w_accept) - c_OUT_W'(w_ack_ok);
      if (w_drop) begin
        r_discard <= r_discard - c_OUT_W'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Prefetch FIFO pointers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_pc_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + c_PTR_W'(1);
      end
      r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
    end
  end

  // Storage needs no reset: entries are only observed while r_count says so.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= w_entry;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign o_stb   = w_stb;
  assign o_adr   = r_fetch_pc;
  assign o_sel   = 4'b1111;
  assign o_we    = 1'b0;
  assign o_dat_w = 32'h0;
  assign o_valid = w_valid;
  assign o_instr = w_head[31:0];
`ifdef FETCH_PC_EN
  assign o_pc    = w_head[63:32];
`endif

  // --------------------------------------------------------------------------
  // Protocol checks
  // --------------------------------------------------------------------------
  a_ack_has_request: assert property (
    @(posedge clk) disable iff (rst) !(i_ack && (r_outstanding == '0))
  );

  a_fifo_no_overflow: assert property (
    @(posedge clk) disable iff (rst) !(w_push && !w_pop && (w_count_ext == DEPTH))
  );

endmodule
`default_nettype wire
